// File: rtl/work_loader_pkg.sv
// Shared definitions for the work loader: header geometry, frame marker and FSM states.
package work_loader_pkg;

  localparam int unsigned HDR_BYTES      = 80;
  localparam int unsigned HDR_W          = HDR_BYTES * 8;
  localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
  localparam int unsigned TIMEOUT_DEF    = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

endpackage

// File: rtl/work_loader.sv
// Assembles framed host bytes into an 80-byte header and hands it to the miner
// through a single-entry valid/ready buffer. `CHECKSUM_EN adds a trailing XOR byte check.
module work_loader
  import work_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic [HDR_W-1:0] work_data_o,
  output logic             work_valid_o,
  input  logic             work_ready_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(HDR_BYTES + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HDR_BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [HDR_W-1:0]   shreg_q, shreg_d;
  logic               cmpl_q, cmpl_d;
  logic [HDR_W-1:0]   work_data_q, work_data_d;
  logic               work_valid_q, work_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
`ifdef CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  logic               tmo_hit_c;
  logic [TMO_W-1:0]   tmo_inc_c;

  // Idle-gap watchdog: fires on the cycle the count would reach the limit.
  assign tmo_hit_c = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
  assign tmo_inc_c = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    shreg_d      = shreg_q;
    cmpl_d       = 1'b0;
    work_data_d  = work_data_q;
    work_valid_d = work_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
`ifdef CHECKSUM_EN
    xor_d        = xor_q;
`endif

    // Output buffer: consume, then possibly refill from a completed frame.
    if (work_valid_q && work_ready_i) begin
      work_valid_d = 1'b0;
    end
    if (cmpl_q) begin
      if (!work_valid_q || work_ready_i) begin
        work_data_d  = shreg_q;
        work_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
          tmo_d   = '0;
`ifdef CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid_i) begin
          shreg_d = {shreg_q[HDR_W-9:0], rx_data_i};
          cnt_d   = cnt_q + CNT_W'(1);
          tmo_d   = '0;
`ifdef CHECKSUM_EN
          xor_d   = xor_q ^ rx_data_i;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_CHECK;
          end
`else
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cmpl_d  = 1'b1;
          end
`endif
        end else if (tmo_hit_c) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_inc_c;
        end
      end

      ST_CHECK: begin
`ifdef CHECKSUM_EN
        if (rx_valid_i) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
          if (rx_data_i == xor_q) begin
            cmpl_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (tmo_hit_c) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_inc_c;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      shreg_q      <= '0;
      cmpl_q       <= 1'b0;
      work_data_q  <= '0;
      work_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      shreg_q      <= shreg_d;
      cmpl_q       <= cmpl_d;
      work_data_q  <= work_data_d;
      work_valid_q <= work_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign work_data_o  = work_data_q;
  assign work_valid_o = work_valid_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule
